maxpool2d_stream: RTL
=====================

# maxpool2d_stream

Parametrised streaming 2×2/stride-2 pooling layer for the CNN datapath. It sits between the ReLU stage and the linear stage. Pixels arrive in raster order, one pixel per beat with all channels packed. It emits one pooled pixel per 2×2 window, selectable between max and average. A one-row line buffer and valid/ready handshakes let it absorb downstream backpressure without dropping data.

## Interface
- `DATA_W`, 8: bits per channel sample.
- `CHANNELS`, 2: channels packed per beat.
- `IMG_W`, 6: input frame width in pixels; must be ≥ 2.
- `IMG_H`, 6: input frame height in pixels; must be ≥ 2.
- `SIGNED`, 0: 1 means samples are two's complement for compare and average.

- `clk`  in  1  single clock, all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous abort of the current frame.
- `avg_mode`  in  1  0 = max pooling, 1 = average pooling; sampled at the frame's first accepted beat.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  input beat accepted when `in_valid & in_ready`.
- `in_data`  in  CHANNELS*DATA_W  channel c in bits [c*DATA_W +: DATA_W].
- `out_valid`  out  1  pooled pixel valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  CHANNELS*DATA_W  pooled pixel, same packing as `in_data`.
- `out_last`  out  1  high with the final pooled pixel of a frame.

## Operation
- Counters `col` (0..IMG_W-1) and `row` (0..IMG_H-1) advance on each accepted beat. `col` wraps to 0 and increments `row`. `row` wraps to 0 after IMG_H-1, which ends the frame.
- Pooled geometry is OW = IMG_W/2 and OH = IMG_H/2 (floor). Column IMG_W-1 (when IMG_W is odd) and row IMG_H-1 (when IMG_H is odd) are accepted and discarded.
- Per channel, in a pooled column and at even `col`: hold the sample in `hold_reg`.
- Per channel, in a pooled column and at odd `col`: form pair result P.
  - Max mode: P = max(hold, in).
  - Average mode: P = hold + in, width DATA_W+1.
- Row state machine:
  - `S_TOP`: even row. Write P to `line_buf[col/2]`, which holds OW entries of CHANNELS×(DATA_W+1) bits.
  - `S_BOT`: odd row. Combine P with `line_buf[col/2]`.
    - Max mode: result = max.
    - Average mode: result = (sum of 4, width DATA_W+2) >> 2. Arithmetic shift when SIGNED=1, so the result is the floor.
    - Load the result into the output register.
  - `S_SKIP`: trailing odd row. Accept beats and discard them.
- State transitions:
  - `S_TOP` → `S_BOT` at the end of the row.
  - `S_BOT` → `S_TOP` at the end of the row if another full row pair remains.
  - `S_BOT` → `S_SKIP` at the end of the row if only the odd trailing row remains.
  - `S_BOT` → `S_TOP` (new frame) at the end of the frame.
  - `S_SKIP` → `S_TOP` (new frame) at the end of the frame.
- `out_last` is set with the output at pooled position (OH-1, OW-1).
- `avg_mode` is latched into `mode_q` when the beat at (row 0, col 0) is accepted. Changes mid-frame are ignored.
- Comparison is signed when SIGNED=1 and unsigned otherwise.

## Timing
- Reset values:
  - `out_valid` = 0, `out_data` = 0, `out_last` = 0.
  - `in_ready` = 1.
  - `col` = 0, `row` = 0, state = `S_TOP`, `mode_q` = 0.
  - `line_buf` and `hold_reg` are don't-care.
- `in_ready` = `!out_valid | out_ready`, combinational, with `flush` forcing it to 0.
- Latency: `out_valid` rises the cycle after the 4th pixel of a window is accepted.
- `out_data` and `out_last` hold stable while `out_valid & !out_ready`.
- Simultaneous output handoff and new result: when `out_ready` and a new result arrive together, the register reloads with no bubble. Throughput is 1 beat/cycle.
- `flush` (one cycle):
  - Clears the counters, state, `out_valid` and `out_last`.
  - Any beat presented that cycle is not accepted.
  - The next accepted beat is (0,0) of a new frame.
- Reset mid-frame behaves like `flush`, plus all outputs return to their reset values immediately, since the reset is asynchronous.
- Back-to-back frames need no idle cycle between them.

## Structure
- Shared package/include `nn_pkg`:
  - `POOL_MAX` = 0, `POOL_AVG` = 1.
  - State encodings `S_TOP`, `S_SKIP`, `S_BOT`.
  - A `clog2` helper.
- Sub-module `pool_pair_reduce`:
  - Parameters `DATA_W`, `SIGNED`.
  - Combinational max or sum of two operands.
  - Instantiated per channel for both the horizontal pair step and the vertical line-buffer step.
- The line buffer is implemented in flops; OW×CHANNELS entries are small.

## Test plan
- Max, IMG 4×4, CHANNELS=1, pixels 0..15 raster, `out_ready`=1 → outputs 5, 7, 13, 15; `out_last` only on 15; each output one cycle after pixels 5, 7, 13 and 15 respectively.
- Average, same stimulus → outputs 2, 4, 10, 12.
- Backpressure: max 4×4; hold `out_ready`=0 from the first output → `out_data`=5 held, `in_ready`=0, no beats lost; release → 7, 13, 15 still in order.
- Odd geometry, IMG 5×5, pixels 0..24, max → 6, 8, 16, 18; column 4 and row 4 consumed; the next frame starts with a correct (0,0) alignment.
- SIGNED=1, CHANNELS=2, window ch0 {-3, -1, -8, -2}, ch1 {1, 2, 3, 4}:
  - max → ch0 = 0xFF (-1), ch1 = 4.
  - avg → ch0 = 0xFC (-4), ch1 = 2.
- Frame abort: assert `flush`, then separately `rst_n`=0, mid-row 1 of a 4×4 frame → `out_valid`=0 immediately; the following full frame gives correct outputs; an `avg_mode` toggle mid-frame has no effect.

Source files
------------

// File: rtl/nn_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared constants for the CNN datapath: pooling mode codes,
//               pooling row-state encodings and a width helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

    // Pooling mode codes, as carried on avg_mode.
    localparam logic c_POOL_MAX = 1'b0;
    localparam logic c_POOL_AVG = 1'b1;

    // Pooling row-state encodings.
    localparam logic [1:0] c_S_TOP  = 2'd0;
    localparam logic [1:0] c_S_SKIP = 2'd1;
    localparam logic [1:0] c_S_BOT  = 2'd2;

    // Ceiling log2, never less than 1 so the result can size a counter or an
    // index even when the count collapses to a single entry.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'sd1 <<< i) < value) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage : nn_pkg
`default_nettype wire

// File: rtl/pool_pair_reduce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pool_pair_reduce
// Description : Combinational reduction of two samples: either the larger of
//               the two or their full-width sum. Operands are sign-extended
//               when SIGNED is non-zero, zero-extended otherwise.
// Ports       : avg_mode  in   c_POOL_MAX selects max, c_POOL_AVG selects sum
//               a, b      in   DATA_W-bit operands
//               result    out  DATA_W+1 bits: extended max, or a+b
// Revision    : 1.0 - initial release
// ============================================================================
module pool_pair_reduce
    import nn_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int SIGNED = 0
) (
    input  logic              avg_mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W:0]   result
);

    logic [DATA_W:0] w_a_ext;
    logic [DATA_W:0] w_b_ext;
    logic            w_a_gt;

    // After extension both operands compare correctly as signed values:
    // zero-extended unsigned samples are always non-negative.
    assign w_a_ext = {(SIGNED != 0) & a[DATA_W-1], a};
    assign w_b_ext = {(SIGNED != 0) & b[DATA_W-1], b};
    assign w_a_gt  = $signed(w_a_ext) > $signed(w_b_ext);

    assign result = (avg_mode == c_POOL_MAX) ? (w_a_gt ? w_a_ext : w_b_ext)
                                             : (w_a_ext + w_b_ext);

endmodule : pool_pair_reduce
`default_nettype wire

// File: rtl/maxpool2d_stream.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : maxpool2d_stream
// Description : Streaming 2x2 / stride-2 max or average pooling. Raster-order
//               pixels with all channels packed per beat; one pooled pixel is
//               produced per window. A one-row line buffer keeps the top-row
//               pair results until the bottom row arrives.
// Ports       : clk        in   rising-edge clock
//               rst_n      in   asynchronous active-low reset
//               flush      in   synchronous frame abort
//               avg_mode   in   0 max, 1 average; latched at pixel (0,0)
//               in_valid   in   input beat valid
//               in_ready   out  input beat accepted when valid & ready
//               in_data    in   CHANNELS x DATA_W, channel c at [c*DATA_W+:DATA_W]
//               out_valid  out  pooled pixel valid
//               out_ready  in   downstream accepts
//               out_data   out  pooled pixel, same packing as in_data
//               out_last   out  final pooled pixel of the frame
// Revision    : 1.0 - initial release
// ============================================================================
module maxpool2d_stream
    import nn_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 2,
    parameter int IMG_W    = 6,
    parameter int IMG_H    = 6,
    parameter int SIGNED   = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         avg_mode,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic                         out_last
);

    localparam int c_OW    = IMG_W / 2;
    localparam int c_OH    = IMG_H / 2;
    localparam int c_COL_W = clog2(IMG_W);
    localparam int c_ROW_W = clog2(IMG_H);
    localparam int c_IDX_W = clog2(c_OW);
    localparam int c_PW    = DATA_W + 1;          // pair-result width
    localparam int c_DW    = CHANNELS * DATA_W;
    localparam int c_LW    = CHANNELS * c_PW;

    localparam logic [c_COL_W-1:0] c_COL_LAST      = c_COL_W'(IMG_W - 1);
    localparam logic [c_COL_W-1:0] c_COL_POOL_LAST = c_COL_W'(2 * c_OW - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST      = c_ROW_W'(IMG_H - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_POOL_LAST = c_ROW_W'(2 * c_OH - 1);
    localparam logic               c_W_ODD         = (IMG_W % 2) != 0;
    localparam logic               c_H_ODD         = (IMG_H % 2) != 0;

    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_mode;
    logic [c_DW-1:0]    r_hold;
    logic [c_LW-1:0]    r_line_buf [c_OW];
    logic               r_out_valid;
    logic [c_DW-1:0]    r_out_data;
    logic               r_out_last;

    logic               w_accept;
    logic               w_col_end;
    logic               w_row_end;
    logic               w_col_pooled;
    logic               w_pair;
    logic               w_load;
    logic               w_pos_last;
    logic [c_IDX_W-1:0] w_lb_idx;
    logic [c_LW-1:0]    w_lb_rd;
    logic [c_LW-1:0]    w_pair_all;
    logic [c_DW-1:0]    w_res;

    // A new result may only be loaded when the output register is empty or
    // being drained this cycle, which is exactly when a beat can be taken.
    assign in_ready  = ~flush & (~r_out_valid | out_ready);
    assign w_accept  = in_valid & in_ready;

    assign w_col_end = (r_col == c_COL_LAST);
    assign w_row_end = w_accept & w_col_end;

    // With an odd width only the last column falls outside every window.
    assign w_col_pooled = ~c_W_ODD | (r_col != c_COL_LAST);
    assign w_pair       = w_accept & r_col[0] & w_col_pooled;
    assign w_load       = w_pair & (r_state == c_S_BOT);
    assign w_pos_last   = (r_row == c_ROW_POOL_LAST) & (r_col == c_COL_POOL_LAST);

    assign w_lb_idx = c_IDX_W'(r_col >> 1);
    assign w_lb_rd  = r_line_buf[w_lb_idx];

    // Per channel: horizontal pair step, then vertical step against the
    // line buffer. The vertical sum is DATA_W+2 bits; dropping its two LSBs
    // is the floor divide by four in both signed and unsigned arithmetic.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_W+1:0] w_vsum;

        pool_pair_reduce #(
            .DATA_W (DATA_W),
            .SIGNED (SIGNED)
        ) u_pair_h (
            .avg_mode (r_mode),
            .a        (r_hold[c*DATA_W +: DATA_W]),
            .b        (in_data[c*DATA_W +: DATA_W]),
            .result   (w_pair_all[c*c_PW +: c_PW])
        );

        pool_pair_reduce #(
            .DATA_W (c_PW),
            .SIGNED (SIGNED)
        ) u_pair_v (
            .avg_mode (r_mode),
            .a        (w_pair_all[c*c_PW +: c_PW]),
            .b        (w_lb_rd[c*c_PW +: c_PW]),
            .result   (w_vsum)
        );

        assign w_res[c*DATA_W +: DATA_W] = (r_mode == c_POOL_AVG) ? w_vsum[DATA_W+1:2]
                                                                  : w_vsum[DATA_W-1:0];
    end

    // Row state machine: next state.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = c_S_TOP;
        end else if (w_row_end) begin
            case (r_state)
                c_S_TOP: w_state_nxt = c_S_BOT;
                c_S_BOT: begin
                    if ((r_row == c_ROW_POOL_LAST) && c_H_ODD) begin
                        w_state_nxt = c_S_SKIP;
                    end else begin
                        w_state_nxt = c_S_TOP;
                    end
                end
                default: w_state_nxt = c_S_TOP;
            endcase
        end
    end

    // Row state machine: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_TOP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters, mode latch and output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_mode      <= c_POOL_MAX;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else if (flush) begin
            r_col       <= '0;
            r_row       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                if ((r_col == '0) && (r_row == '0)) begin
                    r_mode <= avg_mode;
                end
                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + c_ROW_W'(1);
                end else begin
                    r_col <= r_col + c_COL_W'(1);
                end
            end
            if (w_load) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_res;
                r_out_last  <= w_pos_last;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    // Hold register and line buffer carry no reset: every entry is written
    // before it is read within a frame.
    always_ff @(posedge clk) begin
        if (w_accept & ~r_col[0]) begin
            r_hold <= in_data;
        end
        if (w_pair & (r_state == c_S_TOP)) begin
            r_line_buf[w_lb_idx] <= w_pair_all;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;

endmodule : maxpool2d_stream
`default_nettype wire
